gfx_line_buffer: RTL and testbench
==================================

// Module: gfx_line_buffer
// PURPOSE
//  Downstream of the graphics pipeline output. Captures the per-pixel colour stream produced by
//  special-effects blending into a ping-pong pair of scanline buffers, then replays each
//  completed line to the video output over a valid/ready stream. Decouples fixed-rate pixel
//  generation from a back-pressured display sink. Detects and counts dropped lines.
// PARAMETERS
//  WIDTH   240  visible pixels per line (pix_hcount 0..WIDTH-1)
//  HEIGHT  160  visible lines (pix_vcount 0..HEIGHT-1)
// PORTS
//  clock          in   1   single clock for all logic
//  reset          in   1   asynchronous, active-high; clears all state
//  pix_valid      in   1   pix_color/pix_hcount/pix_vcount valid this cycle
//  pix_color      in   16  BGR555 colour; bit 15 ignored
//  pix_hcount     in   8   pixel x
//  pix_vcount     in   8   pixel y
//  out_ready      in   1   sink accepts out_data this cycle
//  out_valid      out  1   out_data holds a pixel
//  out_data       out  OW  pixel colour (OW = 15, or 24 with GFX_LB_RGB888_EN)
//  out_sol        out  1   out_data is pixel 0 of a line
//  out_eol        out  1   out_data is pixel WIDTH-1 of a line
//  out_line       out  8   vcount tag of the line being streamed
//  overflow       out  1   sticky: at least one line dropped since reset
//  drop_count     out  8   dropped lines, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0; both banks empty; wr_bank=0, rd_bank=0; FSM=IDLE; drop flag cleared.
//  Storage: 2 banks x WIDTH x 15 bits; per bank a full flag and 8-bit line tag. Sync read, 1-cycle latency.
//  Write side (accepted = pix_valid && pix_hcount<WIDTH && pix_vcount<HEIGHT; others ignored):
//   - hcount==0: if full[wr_bank] set drop, overflow<=1, drop_count++ (sat); else clear drop.
//   - !drop: mem[wr_bank][hcount] <= pix_color[14:0].
//   - hcount==WIDTH-1 && !drop: full[wr_bank]<=1, tag[wr_bank]<=vcount, wr_bank toggles.
//   - hcount==WIDTH-1 && drop: drop clears, no bank change. Gaps in hcount are not checked.
//  Read FSM: IDLE -> FETCH -> STREAM.
//   - IDLE: full[rd_bank] -> FETCH, rd_x=0, issue read of x=0.
//   - FETCH: load output register; out_valid=1 next cycle (first out_valid 2 cycles after full set).
//   - STREAM: out_data/out_sol/out_eol/out_line stable while out_valid && !out_ready.
//     On handshake with rd_x<WIDTH-1: next pixel valid on next cycle (prefetch, no bubble at
//     steady out_ready=1; throughput 1 pixel/clock).
//     On handshake with out_eol: full[rd_bank]<=0, rd_bank toggles, out_valid<=0, -> IDLE.
//  Simultaneous writer set (wr_bank) and reader clear (rd_bank) on different banks: both apply.
//  Writer never writes a full bank; reader never reads an empty bank; no read/write conflict.
//  Bank freed on eol handshake is writable the next cycle.
//  out_sol=1 iff rd_x==0; out_eol=1 iff rd_x==WIDTH-1; both 0 when out_valid=0.
//  Reset mid-line: partial lines discarded, stream aborts with out_valid=0 immediately.
// CONFIGURATION
//  GFX_LB_RGB888_EN defined: OW=24, out_data = {R5,R5[4:2], G5,G5[4:2], B5,B5[4:2]}
//   (R=bits 4:0, G=9:5, B=14:10 of stored colour), computed on output register load.
//  Undefined: OW=15, out_data = stored BGR555 word unchanged.
// TESTING
//  1 out_ready=1, line vcount=5 of pix_color=x -> 240 beats, out_sol on first, out_eol on last, out_line=5.
//  2 Capture lines 0,1 with out_ready=0, then line 2 -> line 2 dropped, overflow=1, drop_count=1;
//    release ready -> lines 0 then 1 streamed intact.
//  3 out_ready toggling 1/0 every cycle over a line -> out_data held while stalled, all 240 pixels in order.
//  4 GFX_LB_RGB888_EN, pixel 0x7FFF -> 0xFFFFFF; 0x001F -> 0xFF0000; 0x0010 -> 0x840000.
//  5 Assert reset at pixel 100 of stream -> out_valid=0 async, overflow=0, next full line streams from x=0.
//  6 pix_hcount=240 or pix_vcount=160 with pix_valid=1 -> no write, no flag or counter change.

Source files
------------

// File: rtl/gfx_line_buffer.sv
// gfx_line_buffer: ping-pong scanline capture with a valid/ready replay stream.
// Two line banks decouple the fixed-rate pixel writer from a back-pressured
// display sink. A line that finds its target bank still full is dropped and counted.
// Optional feature macro: GFX_LB_RGB888_EN widens out_data to RGB888.
module gfx_line_buffer #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 160,
`ifdef GFX_LB_RGB888_EN
  localparam int OW    = 24
`else
  localparam int OW    = 15
`endif
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pix_valid,
  input  logic [15:0]   pix_color,
  input  logic [7:0]    pix_hcount,
  input  logic [7:0]    pix_vcount,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  output logic          out_sol,
  output logic          out_eol,
  output logic [7:0]    out_line,
  output logic          overflow,
  output logic [7:0]    drop_count
);

  localparam logic [7:0] W_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] W_END  = 8'(WIDTH);
  localparam logic [7:0] H_END  = 8'(HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM} rd_state_t;

  logic [14:0] mem [2][WIDTH];
  logic [14:0] rd_q;
  logic [7:0]  rd_addr;
  logic [7:0]  tag [2];
  logic [1:0]  full;
  logic [1:0]  full_set, full_clr;
  logic        wr_bank, rd_bank, drop;
  logic        accept, line_drop, wr_en, wr_done;
  logic [7:0]  rd_x, x_next;
  logic        handshake, last_hs, load;
  rd_state_t   state, state_d;

  // Bit 15 of the incoming colour carries no information for this block.
  logic unused_msb;
  assign unused_msb = pix_color[15];

  // Colour conversion applied as a pixel enters the output register.
  function automatic logic [OW-1:0] expand(input logic [14:0] c);
`ifdef GFX_LB_RGB888_EN
    return {c[4:0], c[4:2], c[9:5], c[9:7], c[14:10], c[14:12]};
`else
    return c;
`endif
  endfunction

  assign accept    = pix_valid && (pix_hcount < W_END) && (pix_vcount < H_END);
  // The drop decision for a line is taken at pixel 0 and held until its last pixel.
  assign line_drop = (pix_hcount == 8'd0) ? full[wr_bank] : drop;
  assign wr_en     = accept && !line_drop;
  assign wr_done   = wr_en && (pix_hcount == W_LAST);
  assign handshake = out_valid && out_ready;
  assign last_hs   = handshake && out_eol;
  assign full_set  = wr_done ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr  = last_hs ? (2'b01 << rd_bank) : 2'b00;

  // Line storage write port and synchronous read port.
  // NOTE: the pixel array has no reset; its contents are only read after a full flag
  // says the bank was completely rewritten, so clearing it would buy nothing.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_bank][pix_hcount] <= pix_color[14:0];
    rd_q <= mem[rd_bank][rd_addr];
  end

  // Writer bookkeeping: bank selection, drop tracking, line tags and drop statistics.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_bank    <= 1'b0;
      drop       <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
      tag[0]     <= 8'd0;
      tag[1]     <= 8'd0;
    end else if (accept) begin
      if (pix_hcount == 8'd0) begin
        drop <= full[wr_bank];
        if (full[wr_bank]) begin
          overflow <= 1'b1;
          if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
      end
      if (pix_hcount == W_LAST) begin
        drop <= 1'b0;
        if (!line_drop) begin
          tag[wr_bank] <= pix_vcount;
          wr_bank      <= ~wr_bank;
        end
      end
    end
  end

  // Bank full flags: writer sets on line completion, reader clears on the eol handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) full <= 2'b00;
    else       full <= (full | full_set) & ~full_clr;
  end

  // Read FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Read FSM next state, prefetch address and output-register load strobe.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d = state;
    rd_addr = 8'd0;
    load    = 1'b0;
    x_next  = 8'd0;
    unique case (state)
      S_IDLE: begin
        if (full[rd_bank]) state_d = S_FETCH;
      end
      S_FETCH: begin
        load    = 1'b1;
        rd_addr = 8'd1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (handshake) begin
          if (out_eol) begin
            state_d = S_IDLE;
          end else begin
            load    = 1'b1;
            x_next  = rd_x + 8'd1;
            rd_addr = (rd_x < W_LAST - 8'd1) ? rd_x + 8'd2 : 8'd0;
          end
        end else begin
          // Stalled: keep re-reading the already prefetched pixel.
          rd_addr = (rd_x < W_LAST) ? rd_x + 8'd1 : 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register: loads the prefetched pixel, holds while stalled, retires the bank on eol.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
      out_line  <= 8'd0;
      rd_x      <= 8'd0;
      rd_bank   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= expand(rd_q);
      out_sol   <= (x_next == 8'd0);
      out_eol   <= (x_next == W_LAST);
      rd_x      <= x_next;
      if (state == S_FETCH) out_line <= tag[rd_bank];
    end else if (last_hs) begin
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
      rd_bank   <= ~rd_bank;
    end
  end

endmodule

// File: tb/tb_gfx_line_buffer.sv
// tb_gfx_line_buffer: randomized scoreboard bench for gfx_line_buffer.
// The reference model treats the two banks as a two-entry line FIFO: a line is dropped
// when two completed lines are still waiting to be streamed out.
module tb_gfx_line_buffer;
  localparam int WIDTH  = 240;
  localparam int HEIGHT = 160;
`ifdef GFX_LB_RGB888_EN
  localparam int OW = 24;
`else
  localparam int OW = 15;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          pix_valid;
  logic [15:0]   pix_color;
  logic [7:0]    pix_hcount, pix_vcount;
  logic          out_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_sol, out_eol;
  logic [7:0]    out_line;
  logic          overflow;
  logic [7:0]    drop_count;

  always #5 clock = ~clock;

  gfx_line_buffer dut (
    .clock      (clock),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_color  (pix_color),
    .pix_hcount (pix_hcount),
    .pix_vcount (pix_vcount),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sol    (out_sol),
    .out_eol    (out_eol),
    .out_line   (out_line),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  typedef struct packed {
    logic [OW-1:0] data;
    logic          sol;
    logic          eol;
    logic [7:0]    tag;
  } beat_t;

  beat_t         sb[$];
  int            total = 0;
  int            bad = 0;
  int            held = 0;        // completed lines not yet retired by an eol handshake
  int            model_drops = 0;
  int            cyc = 0;
  int            sol_cyc = 0, eol_cyc = 0;
  int            mon_idx = 0;
  int            ready_mode = 0;  // 0 low, 1 high, 2 toggle, 3 random
  logic [15:0]   pat [WIDTH];
  logic [OW-1:0] line_data [WIDTH];

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected output colour from the 5-bit channels using plain arithmetic.
  function automatic logic [OW-1:0] model_px(input logic [15:0] c);
    int r, g, b, v;
    r = int'(c[4:0]);
    g = int'(c[9:5]);
    b = int'(c[14:10]);
`ifdef GFX_LB_RGB888_EN
    v = ((r * 8 + r / 4) << 16) | ((g * 8 + g / 4) << 8) | (b * 8 + b / 4);
`else
    v = (b << 10) | (g << 5) | r;
`endif
    return v[OW-1:0];
  endfunction

  // Sink handshake driver.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(99) < 60);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    logic [OW+9:0] prev_vec;
    logic          prev_stall;
    beat_t         exp_b;
    prev_stall = 1'b0;
    prev_vec   = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (prev_stall) check("stall_hold", {out_data, out_sol, out_eol, out_line}, prev_vec);
        if (out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got data %0h line %0d with no beat expected", out_data, out_line);
          end else begin
            exp_b = sb.pop_front();
            check("data", out_data, exp_b.data);
            check("sol",  out_sol,  exp_b.sol);
            check("eol",  out_eol,  exp_b.eol);
            check("line", out_line, exp_b.tag);
            if (exp_b.sol) begin
              mon_idx = 0;
              sol_cyc = cyc;
            end
            if (mon_idx < WIDTH) line_data[mon_idx] = out_data;
            mon_idx++;
            if (exp_b.eol) begin
              held--;
              eol_cyc = cyc;
            end
          end
        end
        prev_stall = !out_ready;
        prev_vec   = {out_data, out_sol, out_eol, out_line};
      end else begin
        if (prev_stall) check("valid_held", out_valid, 1'b1);
        check("idle_flags", {out_sol, out_eol}, 2'b00);
        prev_stall = 1'b0;
      end
    end
  end

  // One out-of-range or invalid pixel cycle that the DUT must ignore.
  task automatic drive_junk();
    pix_color = 16'($urandom);
    case ($urandom_range(2))
      0: begin
        pix_valid  = 1'b0;
        pix_hcount = 8'($urandom_range(WIDTH - 1));
        pix_vcount = 8'($urandom_range(HEIGHT - 1));
      end
      1: begin
        pix_valid  = 1'b1;
        pix_hcount = 8'($urandom_range(255, WIDTH));
        pix_vcount = 8'($urandom_range(HEIGHT - 1));
      end
      default: begin
        pix_valid  = 1'b1;
        pix_hcount = 8'($urandom_range(WIDTH - 1));
        pix_vcount = 8'($urandom_range(255, HEIGHT));
      end
    endcase
    @(posedge clock);
    #1;
  endtask

  // Writes one line from pat[], with optional junk cycles, and predicts its fate.
  task automatic send_line(input logic [7:0] v, input int gap_pct);
    bit dropping;
    dropping = 1'b0;
    for (int x = 0; x < WIDTH; x++) begin
      while (int'($urandom_range(99)) < gap_pct) drive_junk();
      if (x == 0) begin
        dropping = (held == 2);
        if (dropping) model_drops++;
      end
      pix_valid  = 1'b1;
      pix_hcount = 8'(x);
      pix_vcount = v;
      pix_color  = pat[x];
      if (!dropping) begin
        sb.push_back('{data: model_px(pat[x]), sol: (x == 0), eol: (x == WIDTH - 1), tag: v});
        if (x == WIDTH - 1) held++;
      end
      @(posedge clock);
      #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic fill_random();
    for (int x = 0; x < WIDTH; x++) pat[x] = 16'($urandom);
  endtask

  // Waits for the scoreboard to empty within a cycle budget.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: %0d beats still pending, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    reset      = 1'b1;
    pix_valid  = 1'b0;
    pix_color  = 16'd0;
    pix_hcount = 8'd0;
    pix_vcount = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_valid",      out_valid, 1'b0);
    check("reset_outputs",    {out_data, out_sol, out_eol, out_line}, '0);
    check("reset_overflow",   overflow, 1'b0);
    check("reset_drop_count", drop_count, 8'd0);
    @(posedge clock);
    #1;

    // Constant-colour line at full rate: latency, flags, tag and throughput.
    ready_mode = 1;
    c = 16'($urandom);
    for (int x = 0; x < WIDTH; x++) pat[x] = c;
    send_line(8'd5, 0);
    @(negedge clock);
    @(negedge clock);
    check("latency_not_yet", out_valid, 1'b0);
    @(negedge clock);
    check("latency_first", out_valid, 1'b1);
    drain("t1");
    check("throughput", eol_cyc - sol_cyc, WIDTH - 1);

    // Two lines held by a stalled sink, third line dropped.
    ready_mode = 0;
    fill_random(); send_line(8'd0, 0);
    fill_random(); send_line(8'd1, 0);
    fill_random(); send_line(8'd2, 0);
    @(negedge clock);
    check("t2_overflow", overflow, 1'b1);
    check("t2_drop_count", drop_count, 8'(model_drops));
    check("t2_model_drops", model_drops, 1);
    ready_mode = 1;
    drain("t2");

    // Ready toggling every cycle.
    ready_mode = 2;
    fill_random(); send_line(8'd33, 0);
    drain("t3");

    // Colour conversion corners at the start of a line.
    ready_mode = 3;
    fill_random();
    pat[0] = 16'h7FFF;
    pat[1] = 16'h001F;
    pat[2] = 16'h0010;
    send_line(8'd77, 0);
    drain("t4");
`ifdef GFX_LB_RGB888_EN
    check("rgb_white", line_data[0], 24'hFFFFFF);
    check("rgb_red",   line_data[1], 24'hFF0000);
    check("rgb_half",  line_data[2], 24'h840000);
`else
    check("bgr_white", line_data[0], 15'h7FFF);
    check("bgr_red",   line_data[1], 15'h001F);
    check("bgr_half",  line_data[2], 15'h0010);
`endif

    // Out-of-range pixels while both banks are full must not count as a drop.
    ready_mode = 0;
    fill_random(); send_line(8'd20, 0);
    fill_random(); send_line(8'd21, 0);
    pix_valid = 1'b1; pix_color = 16'h1234;
    pix_hcount = 8'd0;   pix_vcount = 8'd160; @(posedge clock); #1;
    pix_hcount = 8'd240; pix_vcount = 8'd3;   @(posedge clock); #1;
    pix_hcount = 8'd0;   pix_vcount = 8'd255; @(posedge clock); #1;
    pix_hcount = 8'd255; pix_vcount = 8'd255; @(posedge clock); #1;
    pix_valid = 1'b0;
    @(negedge clock);
    check("t6_drop_count", drop_count, 8'(model_drops));
    ready_mode = 1;
    drain("t6");

    // Randomized traffic with junk cycles and a random sink.
    ready_mode = 3;
    for (int i = 0; i < 8; i++) begin
      fill_random();
      send_line(8'($urandom_range(HEIGHT - 1)), 20);
    end
    ready_mode = 1;
    drain("rand");
    @(negedge clock);
    check("rand_drop_count", drop_count, 8'(model_drops));
    check("rand_overflow", overflow, (model_drops > 0));

    // Reset in the middle of a streamed line.
    ready_mode = 1;
    mon_idx = 0;
    fill_random(); send_line(8'd9, 0);
    for (int i = 0; i < 2000 && mon_idx < 100; i++) @(negedge clock);
    check("t5_reached_px100", (mon_idx >= 100), 1'b1);
    check("t5_pre_overflow", overflow, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_valid", out_valid, 1'b0);
    check("t5_overflow", overflow, 1'b0);
    check("t5_drop_count", drop_count, 8'd0);
    sb.delete();
    held = 0;
    model_drops = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    fill_random(); send_line(8'd11, 0);
    drain("t5");
    check("t5_line_len", mon_idx, WIDTH);
    check("t5_final_overflow", overflow, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
